// File: rtl/sched_pkg.sv
// Shared types and default sizing for the time-slice scheduler.
// State encoding and the OS slot number live here so the FSM and bench agree.
package sched_pkg;

    localparam int NUM_PROC_DEF = 8;
    localparam int PROC_W_DEF   = 6;
    localparam int QCNT_W_DEF   = 8;
    localparam int OS_PROC      = 0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_PREEMPT  = 3'd2,
        S_SELECT   = 3'd3,
        S_DISPATCH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/quantum_scheduler_rr_pick.sv
// Combinational round-robin picker: scans from 'start' upward with wrap, skipping slot 0.
module rr_pick
    import sched_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int IDX_W    = $clog2(NUM_PROC)
) (
    input  logic [NUM_PROC-1:0] ready_mask,
    input  logic [IDX_W-1:0]    start,
    output logic [IDX_W-1:0]    winner,
    output logic                found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_PROC; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_PROC) begin
                idx = idx - NUM_PROC;
            end
            if (!found && idx != OS_PROC && ready_mask[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Time-slice round-robin scheduler: quantum counting, preemption request, next-process offer.
// Optional QSCHED_STATS_EN adds saturating swap_count / preempt_count outputs.
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int PROC_W   = PROC_W_DEF,
    parameter int QCNT_W   = QCNT_W_DEF,
    parameter int QUANTUM  = 16
) (
    input  logic                single_clk,
    input  logic                input_reset,
    input  logic                enable,
    input  logic [NUM_PROC-1:0] ready_mask,
    input  logic                proc_done,
    input  logic                preempt_ack,
    input  logic                swap_ack,
    input  logic                quantum_load,
    input  logic [QCNT_W-1:0]   quantum_val,
    output logic                preempt_req,
    output logic                next_valid,
    output logic [PROC_W-1:0]   next_proc,
    output logic [PROC_W-1:0]   cur_proc,
    output logic                idle
`ifdef QSCHED_STATS_EN
    ,
    output logic [15:0]         swap_count,
    output logic [15:0]         preempt_count
`endif
);

    localparam int IDX_W = $clog2(NUM_PROC);

    function automatic logic [QCNT_W-1:0] eff_quantum(input logic [QCNT_W-1:0] q);
        return (q == '0) ? QCNT_W'(1) : q;
    endfunction

`ifdef QSCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    sched_state_t      state;
    logic [QCNT_W-1:0] qcnt;
    logic [QCNT_W-1:0] quantum_reg;
    logic [QCNT_W-1:0] q_active;

    logic [IDX_W-1:0]  cur_idx;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              user_ready;
    logic              expiry;

    assign cur_idx    = cur_proc[IDX_W-1:0];
    assign start_idx  = (int'(cur_idx) == NUM_PROC - 1) ? '0 : cur_idx + IDX_W'(1);
    assign user_ready = |ready_mask[NUM_PROC-1:1];
    assign expiry     = enable && (qcnt == q_active - QCNT_W'(1));

    rr_pick #(
        .NUM_PROC (NUM_PROC),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .ready_mask (ready_mask),
        .start      (start_idx),
        .winner     (pick_idx),
        .found      (pick_found)
    );

    always_ff @(posedge single_clk or negedge input_reset) begin
        if (!input_reset) begin
            state         <= S_IDLE;
            qcnt          <= '0;
            quantum_reg   <= eff_quantum(QCNT_W'(QUANTUM));
            q_active      <= eff_quantum(QCNT_W'(QUANTUM));
            preempt_req   <= 1'b0;
            next_valid    <= 1'b0;
            next_proc     <= '0;
            cur_proc      <= '0;
            idle          <= 1'b1;
`ifdef QSCHED_STATS_EN
            swap_count    <= '0;
            preempt_count <= '0;
`endif
        end else begin
            // A new quantum is staged here and only picked up when a slice restarts.
            if (quantum_load) begin
                quantum_reg <= eff_quantum(quantum_val);
            end

            case (state)
                S_IDLE: begin
                    if (user_ready) begin
                        state <= S_SELECT;
                    end
                end

                S_RUN: begin
                    // proc_done outranks expiry: the hlt already traps to the OS.
                    if (proc_done || !ready_mask[cur_idx]) begin
                        state <= S_SELECT;
                    end else if (expiry) begin
                        state <= S_PREEMPT;
                    end else if (enable) begin
                        qcnt <= qcnt + QCNT_W'(1);
                    end
                end

                S_PREEMPT: begin
                    if (preempt_ack) begin
                        preempt_req <= 1'b0;
                        state       <= S_SELECT;
`ifdef QSCHED_STATS_EN
                        preempt_count <= sat_inc(preempt_count);
`endif
                    end else begin
                        preempt_req <= 1'b1;
                    end
                end

                S_SELECT: begin
                    if (pick_found) begin
                        next_proc  <= PROC_W'(pick_idx);
                        next_valid <= 1'b1;
                        state      <= S_DISPATCH;
                    end else begin
                        next_proc <= PROC_W'(OS_PROC);
                        idle      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                S_DISPATCH: begin
                    if (swap_ack) begin
                        cur_proc   <= next_proc;
                        next_valid <= 1'b0;
                        qcnt       <= '0;
                        q_active   <= quantum_reg;
                        idle       <= 1'b0;
                        state      <= S_RUN;
`ifdef QSCHED_STATS_EN
                        swap_count <= sat_inc(swap_count);
`endif
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler (QUANTUM=16); stats outputs checked when QSCHED_STATS_EN is defined.
module tb_quantum_scheduler;

    logic       single_clk;
    logic       input_reset;
    logic       enable;
    logic [7:0] ready_mask;
    logic       proc_done;
    logic       preempt_ack;
    logic       swap_ack;
    logic       quantum_load;
    logic [7:0] quantum_val;
    logic       preempt_req;
    logic       next_valid;
    logic [5:0] next_proc;
    logic [5:0] cur_proc;
    logic       idle;
`ifdef QSCHED_STATS_EN
    logic [15:0] swap_count;
    logic [15:0] preempt_count;
`endif

    int checks   = 0;
    int failures = 0;

    quantum_scheduler #(
        .NUM_PROC (8),
        .PROC_W   (6),
        .QCNT_W   (8),
        .QUANTUM  (16)
    ) dut (
        .single_clk   (single_clk),
        .input_reset  (input_reset),
        .enable       (enable),
        .ready_mask   (ready_mask),
        .proc_done    (proc_done),
        .preempt_ack  (preempt_ack),
        .swap_ack     (swap_ack),
        .quantum_load (quantum_load),
        .quantum_val  (quantum_val),
        .preempt_req  (preempt_req),
        .next_valid   (next_valid),
        .next_proc    (next_proc),
        .cur_proc     (cur_proc),
        .idle         (idle)
`ifdef QSCHED_STATS_EN
        ,
        .swap_count    (swap_count),
        .preempt_count (preempt_count)
`endif
    );

    initial single_clk = 1'b0;
    always #5 single_clk = ~single_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge single_clk);
            #1;
        end
    endtask

    initial begin
        input_reset  = 1'b0;
        enable       = 1'b0;
        ready_mask   = 8'b0;
        proc_done    = 1'b0;
        preempt_ack  = 1'b0;
        swap_ack     = 1'b0;
        quantum_load = 1'b0;
        quantum_val  = 8'd0;
        #12;
        chk("rst_preempt_req", 32'(preempt_req), 32'd0);
        chk("rst_next_valid",  32'(next_valid),  32'd0);
        chk("rst_next_proc",   32'(next_proc),   32'd0);
        chk("rst_cur_proc",    32'(cur_proc),    32'd0);
        chk("rst_idle",        32'(idle),        32'd1);

        // First dispatch out of reset
        tick(1);
        ready_mask  = 8'b0000_0110;
        input_reset = 1'b1;
        tick(1);
        chk("t1_select_no_offer", 32'(next_valid), 32'd0);
        tick(1);
        chk("t1_next_valid", 32'(next_valid), 32'd1);
        chk("t1_next_proc",  32'(next_proc),  32'd1);
        swap_ack = 1'b1;
        enable   = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        chk("t1_cur_proc",      32'(cur_proc),   32'd1);
        chk("t1_idle",          32'(idle),       32'd0);
        chk("t1_offer_cleared", 32'(next_valid), 32'd0);

        // Quantum expiry, preempt_req on the 17th edge after swap_ack
        tick(16);
        chk("t2_req_before", 32'(preempt_req), 32'd0);
        tick(1);
        chk("t2_req_rise", 32'(preempt_req), 32'd1);
        tick(2);
        chk("t2_req_held", 32'(preempt_req), 32'd1);
        preempt_ack = 1'b1;
        tick(1);
        preempt_ack = 1'b0;
        chk("t2_req_drop",       32'(preempt_req), 32'd0);
        chk("t2_no_offer_yet",   32'(next_valid),  32'd0);
        tick(1);
        chk("t2_next_valid", 32'(next_valid), 32'd1);
        chk("t2_next_proc",  32'(next_proc),  32'd2);
        tick(3);
        chk("t2_offer_held", 32'(next_proc), 32'd2);
        swap_ack = 1'b1;
        enable   = 1'b0;
        tick(1);
        swap_ack = 1'b0;
        chk("t2_cur_proc", 32'(cur_proc), 32'd2);

        // Running process drops out of ready_mask; round-robin with wrap
        ready_mask = 8'b0100_0000;
        tick(2);
        chk("t3_next_proc_6", 32'(next_proc), 32'd6);
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        chk("t3_cur_proc_6", 32'(cur_proc), 32'd6);
        ready_mask = 8'b1000_0010;
        tick(2);
        chk("t3_next_proc_7", 32'(next_proc), 32'd7);
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        chk("t3_cur_proc_7", 32'(cur_proc), 32'd7);
        ready_mask = 8'b0000_0011;
        tick(2);
        chk("t3_wrap_next_proc_1", 32'(next_proc), 32'd1);
        swap_ack = 1'b1;
        enable   = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        chk("t3_cur_proc_1", 32'(cur_proc), 32'd1);

        // proc_done coincides with expiry, then nothing ready
        tick(15);
        proc_done  = 1'b1;
        ready_mask = 8'b0;
        tick(1);
        proc_done = 1'b0;
        chk("t4_no_preempt", 32'(preempt_req), 32'd0);
        tick(1);
        chk("t4_no_preempt2", 32'(preempt_req), 32'd0);
        chk("t4_idle",        32'(idle),        32'd1);
        chk("t4_next_proc_0", 32'(next_proc),   32'd0);
        chk("t4_no_offer",    32'(next_valid),  32'd0);
        swap_ack    = 1'b1;
        preempt_ack = 1'b1;
        proc_done   = 1'b1;
        tick(1);
        swap_ack    = 1'b0;
        preempt_ack = 1'b0;
        proc_done   = 1'b0;
        chk("t4_ignored_swap_cur", 32'(cur_proc),    32'd1);
        chk("t4_ignored_req",      32'(preempt_req), 32'd0);

        // Quantum reload mid-slice and enable freeze
        enable     = 1'b0;
        ready_mask = 8'b0000_0100;
        tick(2);
        chk("t5_next_proc_2", 32'(next_proc),  32'd2);
        chk("t5_next_valid",  32'(next_valid), 32'd1);
        swap_ack = 1'b1;
        tick(1);
        swap_ack     = 1'b0;
        quantum_load = 1'b1;
        quantum_val  = 8'd0;
        tick(1);
        quantum_load = 1'b0;
        enable = 1'b1;
        tick(10);
        enable = 1'b0;
        tick(20);
        chk("t5_frozen_no_req", 32'(preempt_req), 32'd0);
        enable = 1'b1;
        tick(5);
        chk("t5_slice_unchanged", 32'(preempt_req), 32'd0);
        tick(1);
        chk("t5_entry_no_req", 32'(preempt_req), 32'd0);
        tick(1);
        chk("t5_req_rise", 32'(preempt_req), 32'd1);
        preempt_ack = 1'b1;
        tick(1);
        preempt_ack = 1'b0;
        tick(1);
        chk("t5_self_reselect", 32'(next_proc), 32'd2);
        swap_ack = 1'b1;
        tick(1);
        swap_ack = 1'b0;
        tick(1);
        chk("t5_q1_entry_no_req", 32'(preempt_req), 32'd0);
        tick(1);
        chk("t5_q1_req_rise", 32'(preempt_req), 32'd1);
        preempt_ack = 1'b1;
        tick(1);
        preempt_ack = 1'b0;
        tick(1);
        chk("t5_q1_offer", 32'(next_valid), 32'd1);

`ifdef QSCHED_STATS_EN
        chk("stats_swap_count",    32'(swap_count),    32'd7);
        chk("stats_preempt_count", 32'(preempt_count), 32'd3);
`endif

        // Asynchronous reset while an offer is pending
        #2;
        input_reset = 1'b0;
        #1;
        chk("t6_next_valid", 32'(next_valid), 32'd0);
        chk("t6_cur_proc",   32'(cur_proc),   32'd0);
        chk("t6_next_proc",  32'(next_proc),  32'd0);
        chk("t6_idle",       32'(idle),       32'd1);
`ifdef QSCHED_STATS_EN
        chk("t6_swap_count", 32'(swap_count), 32'd0);
`endif
        tick(2);
        input_reset = 1'b1;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
